multiport_register_file: RTL and testbench

//  Parametrised multi-port register file with a per-register busy scoreboard.
//  - Configurable read/write port counts, depth and width.
//  - Registered reads with optional write-to-read bypass; optional hardwired zero register.
//  - Sits between decode (reads, reserve) and writeback (writes, busy clear) in the core pipeline.

---
 rtl/multiport_register_file.sv | 116 +++++++++++
 tb/tb_multiport_register_file.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/multiport_register_file.sv
// Multi-port register file with registered reads, optional write-to-read bypass,
// optional hardwired zero register and a per-register busy scoreboard.
module multiport_register_file #(
  parameter int WordSize   = 32,
  parameter int RegCount   = 32,
  parameter int ReadPorts  = 2,
  parameter int WritePorts = 2,
  parameter int ZeroReg    = 1,
  parameter int Bypass     = 1,
  localparam int AddrWidth = $clog2(RegCount)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [WritePorts-1:0]           we,
  input  logic [WritePorts*AddrWidth-1:0] wrAddr,
  input  logic [WritePorts*WordSize-1:0]  wrData,
  input  logic [ReadPorts-1:0]            rdEn,
  input  logic [ReadPorts*AddrWidth-1:0]  rdAddr,
  output logic [ReadPorts*WordSize-1:0]   rdData,
  output logic [ReadPorts-1:0]            rdValid,
  output logic [ReadPorts-1:0]            rdBusy,
  input  logic                            resvEn,
  input  logic [AddrWidth-1:0]            resvAddr
);

  logic [WordSize-1:0]           regs_r      [RegCount];
  logic [WordSize-1:0]           regs_next_s [RegCount];
  logic [RegCount-1:0]           busy_r;
  logic [RegCount-1:0]           busy_next_s;
  logic [ReadPorts*WordSize-1:0] rd_data_r;
  logic [ReadPorts*WordSize-1:0] rd_data_next_s;
  logic [ReadPorts-1:0]          rd_valid_r;
  logic [ReadPorts-1:0]          rd_valid_next_s;
  logic [ReadPorts-1:0]          rd_busy_r;
  logic [ReadPorts-1:0]          rd_busy_next_s;

  // A register index can hold state unless it is the hardwired zero register
  function automatic logic reg_writable(input int k);
    reg_writable = !((ZeroReg != 0) && (k == 0));
  endfunction

  // An address names real, non-hardwired storage
  function automatic logic addr_ok(input logic [AddrWidth-1:0] a);
    addr_ok = (int'(a) < RegCount) &&
              !((ZeroReg != 0) && (a == {AddrWidth{1'b0}}));
  endfunction

  // Post-edge array and scoreboard: ascending port order lets the highest port win,
  // and the reserve is applied last so a new producer overrides a same-cycle clear
  always_comb begin
    for (int k = 0; k < RegCount; k++) begin
      regs_next_s[k] = regs_r[k];
      busy_next_s[k] = busy_r[k];
      for (int p = 0; p < WritePorts; p++) begin
        logic hit_v;
        hit_v = we[p] && (wrAddr[p*AddrWidth +: AddrWidth] == AddrWidth'(k)) && reg_writable(k);
        regs_next_s[k] = hit_v ? wrData[p*WordSize +: WordSize] : regs_next_s[k];
        busy_next_s[k] = hit_v ? 1'b0 : busy_next_s[k];
      end
      busy_next_s[k] = (resvEn && (resvAddr == AddrWidth'(k)) && reg_writable(k)) ?
                       1'b1 : busy_next_s[k];
    end
  end

  // Read port next values; idle ports hold data and busy, drop valid
  always_comb begin
    rd_data_next_s  = rd_data_r;
    rd_busy_next_s  = rd_busy_r;
    rd_valid_next_s = {ReadPorts{1'b0}};
    for (int r = 0; r < ReadPorts; r++) begin
      logic [AddrWidth-1:0] addr_v;
      addr_v = rdAddr[r*AddrWidth +: AddrWidth];
      if (rdEn[r]) begin
        rd_valid_next_s[r] = 1'b1;
        if (!addr_ok(addr_v)) begin
          rd_data_next_s[r*WordSize +: WordSize] = {WordSize{1'b0}};
          rd_busy_next_s[r]                      = 1'b0;
        end else if (Bypass != 0) begin
          rd_data_next_s[r*WordSize +: WordSize] = regs_next_s[addr_v];
          rd_busy_next_s[r]                      = busy_next_s[addr_v];
        end else begin
          rd_data_next_s[r*WordSize +: WordSize] = regs_r[addr_v];
          rd_busy_next_s[r]                      = busy_r[addr_v];
        end
      end else begin
        rd_valid_next_s[r] = 1'b0;
      end
    end
  end

  // State and output registers; reset overrides every same-cycle request
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < RegCount; k++) begin
        regs_r[k] <= {WordSize{1'b0}};
      end
      busy_r     <= {RegCount{1'b0}};
      rd_data_r  <= {(ReadPorts*WordSize){1'b0}};
      rd_valid_r <= {ReadPorts{1'b0}};
      rd_busy_r  <= {ReadPorts{1'b0}};
    end else begin
      for (int k = 0; k < RegCount; k++) begin
        regs_r[k] <= regs_next_s[k];
      end
      busy_r     <= busy_next_s;
      rd_data_r  <= rd_data_next_s;
      rd_valid_r <= rd_valid_next_s;
      rd_busy_r  <= rd_busy_next_s;
    end
  end

  assign rdData  = rd_data_r;
  assign rdValid = rd_valid_r;
  assign rdBusy  = rd_busy_r;

endmodule

// File: tb/tb_multiport_register_file.sv
// Randomised bench: dut_a (24 regs, zero reg, bypass) and dut_b (32 regs, no zero reg,
// no bypass) share stimulus and are compared each cycle against an array-based model.
module tb_multiport_register_file;
  localparam int W  = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic clk;
  logic reset;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] wrAddr;
  logic [NW*W-1:0]  wrData;
  logic [NR-1:0]    rdEn;
  logic [NR*AW-1:0] rdAddr;
  logic             resvEn;
  logic [AW-1:0]    resvAddr;
  logic [NR*W-1:0]  rdDataA, rdDataB;
  logic [NR-1:0]    rdValidA, rdValidB, rdBusyA, rdBusyB;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  multiport_register_file #(.WordSize(32), .RegCount(24), .ReadPorts(2), .WritePorts(2),
                            .ZeroReg(1), .Bypass(1)) dut_a (
    .clk(clk), .reset(reset), .we(we), .wrAddr(wrAddr), .wrData(wrData),
    .rdEn(rdEn), .rdAddr(rdAddr), .rdData(rdDataA), .rdValid(rdValidA),
    .rdBusy(rdBusyA), .resvEn(resvEn), .resvAddr(resvAddr));

  multiport_register_file #(.WordSize(32), .RegCount(32), .ReadPorts(2), .WritePorts(2),
                            .ZeroReg(0), .Bypass(0)) dut_b (
    .clk(clk), .reset(reset), .we(we), .wrAddr(wrAddr), .wrData(wrData),
    .rdEn(rdEn), .rdAddr(rdAddr), .rdData(rdDataB), .rdValid(rdValidB),
    .rdBusy(rdBusyB), .resvEn(resvEn), .resvAddr(resvAddr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural contents and busy bits per instance
  logic [31:0] mem  [2][32];
  bit          busy [2][32];
  logic [31:0] exp_data  [2][2];
  bit          exp_valid [2][2];
  bit          exp_busy  [2][2];

  function automatic bit legal(int i, int a);
    int limit;
    limit = (i == 0) ? 24 : 32;
    return (a < limit) && !((i == 0) && (a == 0));
  endfunction

  // Predict the upcoming clock edge from the currently driven inputs
  task automatic predict();
    logic [31:0] old_m [32];
    bit          old_b [32];
    int a;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        for (int k = 0; k < 32; k++) begin mem[i][k] = 32'h0; busy[i][k] = 1'b0; end
        for (int r = 0; r < NR; r++) begin
          exp_data[i][r] = 32'h0; exp_valid[i][r] = 1'b0; exp_busy[i][r] = 1'b0;
        end
      end else begin
        for (int k = 0; k < 32; k++) begin old_m[k] = mem[i][k]; old_b[k] = busy[i][k]; end
        for (int p = 0; p < NW; p++) begin
          a = int'(wrAddr[p*AW +: AW]);
          if (we[p] && legal(i, a)) begin
            mem[i][a]  = wrData[p*W +: W];
            busy[i][a] = 1'b0;
          end
        end
        if (resvEn && legal(i, int'(resvAddr))) busy[i][int'(resvAddr)] = 1'b1;
        for (int r = 0; r < NR; r++) begin
          a = int'(rdAddr[r*AW +: AW]);
          exp_valid[i][r] = rdEn[r];
          if (rdEn[r]) begin
            if (!legal(i, a)) begin
              exp_data[i][r] = 32'h0; exp_busy[i][r] = 1'b0;
            end else if (i == 0) begin
              exp_data[i][r] = mem[i][a]; exp_busy[i][r] = busy[i][a];
            end else begin
              exp_data[i][r] = old_m[a]; exp_busy[i][r] = old_b[a];
            end
          end
        end
      end
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  logic [NR*W-1:0] cmp_d;
  logic [NR-1:0]   cmp_v, cmp_b;
  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < 2; i++) begin
        cmp_d = (i == 0) ? rdDataA  : rdDataB;
        cmp_v = (i == 0) ? rdValidA : rdValidB;
        cmp_b = (i == 0) ? rdBusyA  : rdBusyB;
        for (int r = 0; r < NR; r++) begin
          check($sformatf("model dut%0d rdData[%0d] t=%0t", i, r, $time),
                cmp_d[r*W +: W], exp_data[i][r]);
          check($sformatf("model dut%0d rdValid[%0d] t=%0t", i, r, $time),
                {31'h0, cmp_v[r]}, {31'h0, exp_valid[i][r]});
          check($sformatf("model dut%0d rdBusy[%0d] t=%0t", i, r, $time),
                {31'h0, cmp_b[r]}, {31'h0, exp_busy[i][r]});
        end
      end
    end
  end

  task automatic clear_inputs();
    we = 2'b00; wrAddr = '0; wrData = '0; rdEn = 2'b00; rdAddr = '0;
    resvEn = 1'b0; resvAddr = 5'd0; reset = 1'b0;
  endtask

  // Commit current inputs to the model, then advance to just after the next negedge
  task automatic step();
    predict();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [4:0] rand_addr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 11));
  endfunction

  initial begin
    clear_inputs();
    reset = 1'b1;
    predict();
    check_en = 1'b1;
    @(negedge clk); #1;
    clear_inputs(); reset = 1'b1; step();

    // read after reset
    clear_inputs(); rdEn = 2'b11; rdAddr = {5'd5, 5'd5}; step();
    check("reset rdDataA", rdDataA[31:0], 32'h0);
    check("reset rdDataA p1", rdDataA[63:32], 32'h0);
    check("reset rdValidA", {30'h0, rdValidA}, 32'd3);
    check("reset rdBusyA", {30'h0, rdBusyA}, 32'd0);

    // plain write then read on port 1
    clear_inputs(); we = 2'b01; wrAddr = {5'd0, 5'd3}; wrData = {32'h0, 32'hDEAD_BEEF}; step();
    clear_inputs(); rdEn = 2'b10; rdAddr = {5'd3, 5'd0}; step();
    check("write-read A", rdDataA[63:32], 32'hDEAD_BEEF);
    check("write-read B", rdDataB[63:32], 32'hDEAD_BEEF);

    // two ports collide on 7 while port 0 reads 7
    clear_inputs(); we = 2'b11; wrAddr = {5'd7, 5'd7}; wrData = {32'd2, 32'd1};
    rdEn = 2'b01; rdAddr = {5'd0, 5'd7}; step();
    check("collide bypass A", rdDataA[31:0], 32'd2);
    check("collide nobypass B", rdDataB[31:0], 32'd0);
    clear_inputs(); rdEn = 2'b01; rdAddr = {5'd0, 5'd7}; step();
    check("collide later A", rdDataA[31:0], 32'd2);
    check("collide later B", rdDataB[31:0], 32'd2);

    // write to register 0
    clear_inputs(); we = 2'b01; wrAddr = {5'd0, 5'd0}; wrData = {32'h0, 32'hFFFF_FFFF}; step();
    clear_inputs(); rdEn = 2'b01; rdAddr = {5'd0, 5'd0}; step();
    check("zero reg A", rdDataA[31:0], 32'h0);
    check("zero reg B", rdDataB[31:0], 32'hFFFF_FFFF);

    // scoreboard: reserve, clear by write, reserve beats clear
    clear_inputs(); resvEn = 1'b1; resvAddr = 5'd9; step();
    clear_inputs(); rdEn = 2'b01; rdAddr = {5'd0, 5'd9}; step();
    check("busy set A", {31'h0, rdBusyA[0]}, 32'd1);
    clear_inputs(); we = 2'b01; wrAddr = {5'd0, 5'd9}; wrData = {32'h0, 32'h55};
    rdEn = 2'b01; rdAddr = {5'd0, 5'd9}; step();
    check("busy clear bypass A", {31'h0, rdBusyA[0]}, 32'd0);
    check("busy clear nobypass B", {31'h0, rdBusyB[0]}, 32'd1);
    clear_inputs(); we = 2'b01; wrAddr = {5'd0, 5'd9}; wrData = {32'h0, 32'h66};
    resvEn = 1'b1; resvAddr = 5'd9; step();
    clear_inputs(); rdEn = 2'b01; rdAddr = {5'd0, 5'd9}; step();
    check("resv wins A", {31'h0, rdBusyA[0]}, 32'd1);
    check("resv wins data A", rdDataA[31:0], 32'h66);

    // address beyond dut_a's 24 registers
    clear_inputs(); we = 2'b10; wrAddr = {5'd25, 5'd0}; wrData = {32'h1234_5678, 32'h0};
    resvEn = 1'b1; resvAddr = 5'd25; step();
    clear_inputs(); rdEn = 2'b01; rdAddr = {5'd0, 5'd25}; step();
    check("out of range data A", rdDataA[31:0], 32'h0);
    check("out of range busy A", {31'h0, rdBusyA[0]}, 32'd0);
    check("in range data B", rdDataB[31:0], 32'h1234_5678);
    check("in range busy B", {31'h0, rdBusyB[0]}, 32'd1);

    // randomised traffic with occasional reset
    for (int n = 0; n < 800; n++) begin
      we       = 2'($urandom_range(0, 3));
      wrAddr   = {rand_addr(), rand_addr()};
      wrData   = {$urandom(), $urandom()};
      rdEn     = 2'($urandom_range(0, 3));
      rdAddr   = {rand_addr(), rand_addr()};
      resvEn   = ($urandom_range(0, 2) == 0);
      resvAddr = rand_addr();
      reset    = ($urandom_range(0, 99) == 0);
      step();
    end

    // mid-stream reset with everything active
    clear_inputs(); we = 2'b11; wrAddr = {5'd4, 5'd3}; wrData = {32'hAAAA_0004, 32'hAAAA_0003};
    resvEn = 1'b1; resvAddr = 5'd4; step();
    we = 2'b11; wrAddr = {5'd6, 5'd5}; wrData = {$urandom(), $urandom()};
    resvEn = 1'b1; resvAddr = 5'd3; rdEn = 2'b11; rdAddr = {5'd4, 5'd3}; reset = 1'b1; step();
    check("midreset rdValidA", {30'h0, rdValidA}, 32'd0);
    check("midreset rdValidB", {30'h0, rdValidB}, 32'd0);
    check("midreset rdDataA", rdDataA[31:0], 32'h0);
    check("midreset rdBusyB", {30'h0, rdBusyB}, 32'd0);
    clear_inputs(); rdEn = 2'b11; rdAddr = {5'd4, 5'd3}; step();
    check("postreset rdDataA", rdDataA[63:32], 32'h0);
    check("postreset rdDataB", rdDataB[31:0], 32'h0);
    check("postreset rdBusyA", {30'h0, rdBusyA}, 32'd0);
    check("postreset rdValidB", {30'h0, rdValidB}, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
